// File: rtl/ex_alu_branch_fwd.sv
// Execute stage: operand forwarding, ALU, branch resolution, and the EX/MEM output register.
// The redirect (flush_o/br_target_o) and the load address are combinational; the result is registered.
module ex_alu_branch_fwd #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            valid_i,
    input  logic            stall_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic [XLEN-1:0] imm_i,
    input  logic            use_imm_i,
    input  logic [3:0]      alu_op_i,
    input  logic [XLEN-1:0] rs1_data_i,
    input  logic [XLEN-1:0] rs2_data_i,
    input  logic [1:0]      rs1_sel_i,
    input  logic [1:0]      rs2_sel_i,
    input  logic [XLEN-1:0] mem_byp_i,
    input  logic [XLEN-1:0] wb_byp_i,
    input  logic [XLEN-1:0] wb_late_byp_i,
    input  logic            is_branch_i,
    input  logic [2:0]      br_op_i,
    input  logic [4:0]      rd_addr_i,
    input  logic            rd_we_i,
    output logic [XLEN-1:0] res_q_o,
    output logic [4:0]      rd_addr_q_o,
    output logic            rd_we_q_o,
    output logic            valid_q_o,
    output logic            flush_o,
    output logic [XLEN-1:0] br_target_o,
    output logic [XLEN-1:0] ld_addr_o
);

    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_SLL   = 4'd2,
        ALU_SLT   = 4'd3,
        ALU_SLTU  = 4'd4,
        ALU_XOR   = 4'd5,
        ALU_SRL   = 4'd6,
        ALU_SRA   = 4'd7,
        ALU_OR    = 4'd8,
        ALU_AND   = 4'd9,
        ALU_LUI   = 4'd10,
        ALU_AUIPC = 4'd11
    } alu_op_e;

    typedef enum logic [2:0] {
        BR_BEQ  = 3'd0,
        BR_BNE  = 3'd1,
        BR_JAL  = 3'd2,
        BR_JALR = 3'd3,
        BR_BLT  = 3'd4,
        BR_BGE  = 3'd5,
        BR_BLTU = 3'd6,
        BR_BGEU = 3'd7
    } br_op_e;

    logic [XLEN-1:0] rs1f, rs2f, op_b, alu_res, rs1_plus_imm, pc_plus_imm, result;
    logic [4:0]      shamt;
    logic            lt_s, lt_u, eq, taken;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        rs1f = rs1_data_i;
        case (rs1_sel_i)
            2'd1:    rs1f = mem_byp_i;
            2'd2:    rs1f = wb_byp_i;
            2'd3:    rs1f = wb_late_byp_i;
            default: rs1f = rs1_data_i;
        endcase
    end

    always_comb begin
        rs2f = rs2_data_i;
        case (rs2_sel_i)
            2'd1:    rs2f = mem_byp_i;
            2'd2:    rs2f = wb_byp_i;
            2'd3:    rs2f = wb_late_byp_i;
            default: rs2f = rs2_data_i;
        endcase
    end

    assign op_b         = use_imm_i ? imm_i : rs2f;
    assign shamt        = op_b[4:0];
    assign rs1_plus_imm = rs1f + imm_i;
    assign pc_plus_imm  = pc_i + imm_i;
    assign ld_addr_o    = rs1_plus_imm;

    // The ALU compares against op_b; branches always compare the two forwarded registers.
    always_comb begin
        alu_res = '0;
        case (alu_op_e'(alu_op_i))
            ALU_ADD:   alu_res = rs1f + op_b;
            ALU_SUB:   alu_res = rs1f - op_b;
            ALU_SLL:   alu_res = rs1f << shamt;
            ALU_SLT:   alu_res = {{(XLEN-1){1'b0}}, $signed(rs1f) < $signed(op_b)};
            ALU_SLTU:  alu_res = {{(XLEN-1){1'b0}}, rs1f < op_b};
            ALU_XOR:   alu_res = rs1f ^ op_b;
            ALU_SRL:   alu_res = rs1f >> shamt;
            ALU_SRA:   alu_res = $unsigned($signed(rs1f) >>> shamt);
            ALU_OR:    alu_res = rs1f | op_b;
            ALU_AND:   alu_res = rs1f & op_b;
            ALU_LUI:   alu_res = imm_i;
            ALU_AUIPC: alu_res = pc_plus_imm;
            default:   alu_res = '0;
        endcase
    end

    assign eq   = (rs1f == rs2f);
    assign lt_s = ($signed(rs1f) < $signed(rs2f));
    assign lt_u = (rs1f < rs2f);

    always_comb begin
        taken = 1'b0;
        case (br_op_e'(br_op_i))
            BR_BEQ:  taken = eq;
            BR_BNE:  taken = !eq;
            BR_JAL:  taken = 1'b1;
            BR_JALR: taken = 1'b1;
            BR_BLT:  taken = lt_s;
            BR_BGE:  taken = !lt_s;
            BR_BLTU: taken = lt_u;
            BR_BGEU: taken = !lt_u;
            default: taken = 1'b0;
        endcase
    end

    assign br_target_o = (br_op_e'(br_op_i) == BR_JALR) ? {rs1_plus_imm[XLEN-1:1], 1'b0}
                                                         : pc_plus_imm;
    assign flush_o     = valid_i & is_branch_i & taken & ~stall_i;
    assign result      = is_branch_i ? (pc_i + XLEN'(4)) : alu_res;

    // A stall pushes a full bubble: every output register is cleared, not just the valid bit.
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            res_q_o     <= '0;
            rd_addr_q_o <= '0;
            rd_we_q_o   <= 1'b0;
            valid_q_o   <= 1'b0;
        end else if (stall_i) begin
            res_q_o     <= '0;
            rd_addr_q_o <= '0;
            rd_we_q_o   <= 1'b0;
            valid_q_o   <= 1'b0;
        end else begin
            res_q_o     <= result;
            rd_addr_q_o <= rd_addr_i;
            rd_we_q_o   <= rd_we_i & valid_i;
            valid_q_o   <= valid_i;
        end
    end

endmodule

// File: tb/tb_ex_alu_branch_fwd.sv
// Directed, table-driven bench for ex_alu_branch_fwd plus hand-written reset sequences.
module tb_ex_alu_branch_fwd;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_i, stall_i, use_imm_i, is_branch_i, rd_we_i;
    logic [31:0] pc_i, imm_i, rs1_data_i, rs2_data_i, mem_byp_i, wb_byp_i, wb_late_byp_i;
    logic [3:0]  alu_op_i;
    logic [1:0]  rs1_sel_i, rs2_sel_i;
    logic [2:0]  br_op_i;
    logic [4:0]  rd_addr_i;
    logic [31:0] res_q_o, br_target_o, ld_addr_o;
    logic [4:0]  rd_addr_q_o;
    logic        rd_we_q_o, valid_q_o, flush_o;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    ex_alu_branch_fwd #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .valid_i(valid_i), .stall_i(stall_i), .pc_i(pc_i), .imm_i(imm_i),
        .use_imm_i(use_imm_i), .alu_op_i(alu_op_i), .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i),
        .rs1_sel_i(rs1_sel_i), .rs2_sel_i(rs2_sel_i), .mem_byp_i(mem_byp_i), .wb_byp_i(wb_byp_i),
        .wb_late_byp_i(wb_late_byp_i), .is_branch_i(is_branch_i), .br_op_i(br_op_i),
        .rd_addr_i(rd_addr_i), .rd_we_i(rd_we_i), .res_q_o(res_q_o), .rd_addr_q_o(rd_addr_q_o),
        .rd_we_q_o(rd_we_q_o), .valid_q_o(valid_q_o), .flush_o(flush_o),
        .br_target_o(br_target_o), .ld_addr_o(ld_addr_o)
    );

    typedef struct {
        string       name;
        logic        valid, stall, use_imm, is_branch, rd_we;
        logic [31:0] pc, imm, rs1, rs2, mem, wb, wbl;
        logic [3:0]  alu_op;
        logic [1:0]  s1, s2;
        logic [2:0]  br_op;
        logic [4:0]  rd;
        logic [31:0] e_res, e_tgt, e_ld;
        logic [4:0]  e_rd;
        logic        e_we, e_valid, e_flush;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t dflt(string name);
        vec_t v;
        v.name = name;
        v.valid = 1'b1; v.stall = 1'b0; v.use_imm = 1'b0; v.is_branch = 1'b0; v.rd_we = 1'b1;
        v.pc = 32'h100; v.imm = 32'h0; v.rs1 = 32'h0; v.rs2 = 32'h0;
        v.mem = 32'h0; v.wb = 32'h0; v.wbl = 32'h0;
        v.alu_op = 4'd0; v.s1 = 2'd0; v.s2 = 2'd0; v.br_op = 3'd0; v.rd = 5'd1;
        v.e_res = 32'h0; v.e_tgt = 32'h100; v.e_ld = 32'h0;
        v.e_rd = 5'd1; v.e_we = 1'b1; v.e_valid = 1'b1; v.e_flush = 1'b0;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        valid_i = v.valid; stall_i = v.stall; use_imm_i = v.use_imm; is_branch_i = v.is_branch;
        rd_we_i = v.rd_we; pc_i = v.pc; imm_i = v.imm; rs1_data_i = v.rs1; rs2_data_i = v.rs2;
        mem_byp_i = v.mem; wb_byp_i = v.wb; wb_late_byp_i = v.wbl; alu_op_i = v.alu_op;
        rs1_sel_i = v.s1; rs2_sel_i = v.s2; br_op_i = v.br_op; rd_addr_i = v.rd;
    endtask

    task automatic check_regs_zero(input string tag);
        check({tag, ".res"}, res_q_o, 32'h0);
        check({tag, ".rd"}, {27'h0, rd_addr_q_o}, 32'h0);
        check({tag, ".we"}, {31'h0, rd_we_q_o}, 32'h0);
        check({tag, ".valid"}, {31'h0, valid_q_o}, 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;

        v = dflt("add_fwd"); v.s1 = 2'd1; v.mem = 5; v.s2 = 2'd3; v.wbl = 7; v.rs1 = 32'h111; v.rs2 = 32'h222;
        v.e_res = 12; v.e_ld = 5; vecs.push_back(v);
        v = dflt("sub_fwd_swap"); v.alu_op = 1; v.s1 = 2'd3; v.wbl = 9; v.s2 = 2'd1; v.mem = 4; v.rs1 = 32'h111;
        v.e_res = 5; v.e_ld = 9; vecs.push_back(v);
        v = dflt("sub_neg"); v.alu_op = 1; v.rs1 = 3; v.rs2 = 5; v.e_res = 32'hFFFF_FFFE; v.e_ld = 3; vecs.push_back(v);
        v = dflt("sll_imm"); v.alu_op = 2; v.rs1 = 1; v.use_imm = 1; v.imm = 32'h24;
        v.e_res = 32'h10; v.e_ld = 32'h25; v.e_tgt = 32'h124; vecs.push_back(v);
        v = dflt("sra"); v.alu_op = 7; v.s1 = 2'd2; v.wb = 32'h8000_0000; v.use_imm = 1; v.imm = 4;
        v.e_res = 32'hF800_0000; v.e_ld = 32'h8000_0004; v.e_tgt = 32'h104; vecs.push_back(v);
        v = dflt("srl"); v.alu_op = 6; v.s1 = 2'd2; v.wb = 32'h8000_0000; v.use_imm = 1; v.imm = 4;
        v.e_res = 32'h0800_0000; v.e_ld = 32'h8000_0004; v.e_tgt = 32'h104; vecs.push_back(v);
        v = dflt("slt"); v.alu_op = 3; v.rs1 = 32'hFFFF_FFFF; v.rs2 = 1; v.e_res = 1; v.e_ld = 32'hFFFF_FFFF; vecs.push_back(v);
        v = dflt("sltu"); v.alu_op = 4; v.rs1 = 32'hFFFF_FFFF; v.rs2 = 1; v.e_res = 0; v.e_ld = 32'hFFFF_FFFF; vecs.push_back(v);
        v = dflt("xor"); v.alu_op = 5; v.rs1 = 32'hF0F0_F0F0; v.rs2 = 32'hFF00_FF00;
        v.e_res = 32'h0FF0_0FF0; v.e_ld = 32'hF0F0_F0F0; vecs.push_back(v);
        v = dflt("or"); v.alu_op = 8; v.rs1 = 32'hF0F0_F0F0; v.rs2 = 32'hFF00_FF00;
        v.e_res = 32'hFFF0_FFF0; v.e_ld = 32'hF0F0_F0F0; vecs.push_back(v);
        v = dflt("and"); v.alu_op = 9; v.rs1 = 32'hF0F0_F0F0; v.rs2 = 32'hFF00_FF00;
        v.e_res = 32'hF000_F000; v.e_ld = 32'hF0F0_F0F0; vecs.push_back(v);
        v = dflt("lui"); v.alu_op = 10; v.imm = 32'h1234_5000; v.rs1 = 0;
        v.e_res = 32'h1234_5000; v.e_ld = 32'h1234_5000; v.e_tgt = 32'h1234_5100; vecs.push_back(v);
        v = dflt("auipc"); v.alu_op = 11; v.imm = 32'h1000; v.e_res = 32'h1100; v.e_ld = 32'h1000; v.e_tgt = 32'h1100; vecs.push_back(v);
        v = dflt("nop13"); v.alu_op = 13; v.rs1 = 5; v.rs2 = 6; v.e_res = 0; v.e_ld = 5; vecs.push_back(v);
        v = dflt("add_wrap"); v.rs1 = 32'hFFFF_FFFF; v.rs2 = 2; v.e_res = 1; v.e_ld = 32'hFFFF_FFFF; vecs.push_back(v);
        v = dflt("add_imm"); v.rs1 = 10; v.rs2 = 100; v.imm = 5; v.use_imm = 1; v.rd = 5'd9; v.e_rd = 5'd9;
        v.e_res = 15; v.e_ld = 15; v.e_tgt = 32'h105; vecs.push_back(v);
        v = dflt("blt"); v.is_branch = 1; v.br_op = 4; v.rs1 = 32'hFFFF_FFFF; v.rs2 = 1; v.imm = 32'h20;
        v.e_flush = 1; v.e_tgt = 32'h120; v.e_res = 32'h104; v.e_ld = 32'h1F; vecs.push_back(v);
        v = dflt("bltu"); v.is_branch = 1; v.br_op = 6; v.rs1 = 32'hFFFF_FFFF; v.rs2 = 1; v.imm = 32'h20;
        v.e_flush = 0; v.e_tgt = 32'h120; v.e_res = 32'h104; v.e_ld = 32'h1F; vecs.push_back(v);
        v = dflt("bge"); v.is_branch = 1; v.br_op = 5; v.rs1 = 32'hFFFF_FFFF; v.rs2 = 1; v.imm = 32'h20;
        v.e_flush = 0; v.e_tgt = 32'h120; v.e_res = 32'h104; v.e_ld = 32'h1F; vecs.push_back(v);
        v = dflt("bgeu"); v.is_branch = 1; v.br_op = 7; v.rs1 = 32'hFFFF_FFFF; v.rs2 = 1; v.imm = 32'h20;
        v.e_flush = 1; v.e_tgt = 32'h120; v.e_res = 32'h104; v.e_ld = 32'h1F; vecs.push_back(v);
        v = dflt("jalr"); v.is_branch = 1; v.br_op = 3; v.rs1 = 32'h1001; v.imm = 2;
        v.e_flush = 1; v.e_tgt = 32'h1002; v.e_res = 32'h104; v.e_ld = 32'h1003; vecs.push_back(v);
        v = dflt("jal"); v.is_branch = 1; v.br_op = 2; v.rs1 = 32'h55; v.imm = 32'h40;
        v.e_flush = 1; v.e_tgt = 32'h140; v.e_res = 32'h104; v.e_ld = 32'h95; vecs.push_back(v);
        v = dflt("beq_stall"); v.is_branch = 1; v.br_op = 0; v.rs1 = 7; v.rs2 = 7; v.imm = 8; v.stall = 1;
        v.e_flush = 0; v.e_tgt = 32'h108; v.e_ld = 32'hF;
        v.e_res = 0; v.e_rd = 0; v.e_we = 0; v.e_valid = 0; vecs.push_back(v);
        v = dflt("beq_taken"); v.is_branch = 1; v.br_op = 0; v.rs1 = 7; v.rs2 = 7; v.imm = 8;
        v.e_flush = 1; v.e_tgt = 32'h108; v.e_res = 32'h104; v.e_ld = 32'hF; vecs.push_back(v);
        v = dflt("beq_nt"); v.is_branch = 1; v.br_op = 0; v.rs1 = 7; v.rs2 = 8; v.imm = 8;
        v.e_flush = 0; v.e_tgt = 32'h108; v.e_res = 32'h104; v.e_ld = 32'hF; vecs.push_back(v);
        v = dflt("bne"); v.is_branch = 1; v.br_op = 1; v.rs1 = 7; v.rs2 = 8; v.imm = 8;
        v.e_flush = 1; v.e_tgt = 32'h108; v.e_res = 32'h104; v.e_ld = 32'hF; vecs.push_back(v);
        v = dflt("jal_invalid"); v.valid = 0; v.is_branch = 1; v.br_op = 2; v.imm = 32'h40;
        v.e_flush = 0; v.e_tgt = 32'h140; v.e_res = 32'h104; v.e_ld = 32'h40; v.e_we = 0; v.e_valid = 0; vecs.push_back(v);
        v = dflt("no_we"); v.rd_we = 0; v.rd = 5'd31; v.rs1 = 2; v.rs2 = 3;
        v.e_res = 5; v.e_ld = 2; v.e_rd = 5'd31; v.e_we = 0; vecs.push_back(v);

        // Reset is asserted at time zero: registered outputs must be clear before any edge.
        rst = 1'b0;
        drive(dflt("idle"));
        #1;
        check_regs_zero("reset_async");
        repeat (2) @(negedge clk);
        rst = 1'b1;

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i]);
            #1;
            check({vecs[i].name, ".flush"}, {31'h0, flush_o}, {31'h0, vecs[i].e_flush});
            check({vecs[i].name, ".target"}, br_target_o, vecs[i].e_tgt);
            check({vecs[i].name, ".ld_addr"}, ld_addr_o, vecs[i].e_ld);
            @(posedge clk);
            #1;
            check({vecs[i].name, ".res"}, res_q_o, vecs[i].e_res);
            check({vecs[i].name, ".rd"}, {27'h0, rd_addr_q_o}, {27'h0, vecs[i].e_rd});
            check({vecs[i].name, ".we"}, {31'h0, rd_we_q_o}, {31'h0, vecs[i].e_we});
            check({vecs[i].name, ".valid"}, {31'h0, valid_q_o}, {31'h0, vecs[i].e_valid});
        end

        // Mid-operation reset between edges discards the in-flight result immediately.
        @(negedge clk);
        v = dflt("inflight"); v.rs1 = 40; v.rs2 = 2; v.rd = 5'd7;
        drive(v);
        @(posedge clk);
        #1;
        check("inflight.valid_pre", {31'h0, valid_q_o}, 32'h1);
        check("inflight.res_pre", res_q_o, 32'd42);
        #2;
        rst = 1'b0;
        #1;
        check_regs_zero("reset_mid");
        check("reset_mid.ld_addr", ld_addr_o, 32'd40);
        @(posedge clk);
        #1;
        check_regs_zero("reset_held");

        // First capture happens on the first rising edge after release.
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("post_reset.res", res_q_o, 32'd42);
        check("post_reset.rd", {27'h0, rd_addr_q_o}, 32'd7);
        check("post_reset.valid", {31'h0, valid_q_o}, 32'h1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ex_alu_branch_fwd.md
EX_ALU_BRANCH_FWD -- requirements
Module: ex_alu_branch_fwd

Interface
REQ-001 Parameter: XLEN, default 32, datapath width; only 32 is supported.
REQ-002 Port: clk  input  1  rising-edge clock for all state.
REQ-003 Port: rst  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-004 Port: valid_i  input  1  the execute-stage instruction is valid.
REQ-005 Port: stall_i  input  1  pipeline stall; forces a bubble into the output register.
REQ-006 Port: pc_i  input  32  PC of the instruction.
REQ-007 Port: imm_i  input  32  sign-extended immediate.
REQ-008 Port: use_imm_i  input  1  ALU operand B = imm_i when 1, else forwarded rs2.
REQ-009 Port: alu_op_i  input  4  ALU operation code, encoded per REQ-022.
REQ-010 Port: rs1_data_i, rs2_data_i  input  32 each  register-file read data.
REQ-011 Port: rs1_sel_i, rs2_sel_i  input  2 each  forward select: 0 regfile, 1 mem bypass, 2 wb bypass, 3 wb late bypass.
REQ-012 Port: mem_byp_i, wb_byp_i, wb_late_byp_i  input  32 each  bypass data.
REQ-013 Port: is_branch_i  input  1  instruction is a branch or jump.
REQ-014 Port: br_op_i  input  3  branch operation: 0 BEQ, 1 BNE, 2 JAL, 3 JALR, 4 BLT, 5 BGE, 6 BLTU, 7 BGEU.
REQ-015 Port: rd_addr_i  input  5 and rd_we_i  input  1  destination register and its write enable.
REQ-016 Port: res_q_o  output  32  registered result.
REQ-017 Port: rd_addr_q_o  output  5, rd_we_q_o  output  1, valid_q_o  output  1  registered destination, write enable and valid.
REQ-018 Port: flush_o  output  1, br_target_o  output  32  combinational redirect request and target.
REQ-019 Port: ld_addr_o  output  32  combinational effective address, rs1f + imm_i.

Function
REQ-020 Forwarded operands rs1f and rs2f SHALL be pure combinational muxes selected by rs1_sel_i and rs2_sel_i; rs1 and rs2 are selected independently.
REQ-021 ALU operand A SHALL be rs1f; operand B SHALL be imm_i when use_imm_i=1, else rs2f.
REQ-022 ALU ops: 0 ADD; 1 SUB; 2 SLL; 3 SLT (signed, 0/1); 4 SLTU; 5 XOR; 6 SRL; 7 SRA; 8 OR; 9 AND; 10 LUI (result=imm_i); 11 AUIPC (pc_i+imm_i); 12-15 NOP (result 0).
REQ-023 Shift amount SHALL be B[4:0]; add and subtract SHALL wrap modulo 2^32 with no overflow flag.
REQ-024 Branch conditions: BEQ/BNE compare rs1f against rs2f; BLT/BGE are signed; BLTU/BGEU are unsigned; JAL and JALR are always taken.
REQ-025 br_target_o SHALL be (rs1f+imm_i) with bit 0 cleared for JALR, and pc_i+imm_i for all other br_op_i values.
REQ-026 flush_o SHALL equal valid_i & is_branch_i & taken & ~stall_i; it is 0 whenever is_branch_i=0.
REQ-027 The registered result SHALL be pc_i+4 (link value) when is_branch_i=1, else the ALU result.
REQ-028 On each rising clk edge with stall_i=0, the output registers SHALL capture result, rd_addr_i, rd_we_i & valid_i, and valid_i; latency is 1 cycle.
REQ-029 On a rising clk edge with stall_i=1, valid_q_o and rd_we_q_o SHALL go to 0 and res_q_o and rd_addr_q_o SHALL go to 0 (bubble).
REQ-030 Inputs with valid_i=0 SHALL produce rd_we_q_o=0 and flush_o=0.
REQ-031 ld_addr_o SHALL be rs1f+imm_i regardless of alu_op_i, valid_i and stall_i.

Reset
REQ-032 While rst=0, res_q_o, rd_addr_q_o, rd_we_q_o and valid_q_o SHALL be 0 immediately, without waiting for a clock edge.
REQ-033 Combinational outputs SHALL depend on inputs only; reset asserted mid-operation discards the in-flight registered result.
REQ-034 The first capture after reset SHALL occur on the first rising clk edge with rst=1.

Verification
REQ-035 ADD with rs1_sel=1, mem_byp=5 and rs2_sel=3, wb_late_byp=7, use_imm=0 -> res_q_o=12 after one edge.
REQ-036 SRA with rs1f=0x80000000 and imm=4, use_imm=1 -> res_q_o=0xF8000000; SRL with the same operands -> 0x08000000.
REQ-037 BLT with rs1f=0xFFFFFFFF and rs2f=1 -> flush_o=1; BLTU with the same operands -> flush_o=0; br_target=pc+imm in both cases.
REQ-038 JALR with rs1f=0x1001, imm=2, pc=0x100 -> br_target_o=0x1002, flush_o=1, res_q_o=0x104.
REQ-039 Taken BEQ with stall_i=1 -> flush_o=0 and valid_q_o=0 after the edge.
REQ-040 Assert rst=0 between clock edges while valid_q_o=1 -> all registered outputs are 0 immediately.
